simd_lane_acc: RTL and testbench

Lane-wise accumulator placed directly downstream of the 8-bit SIMD adder. It consumes the adder's 8-bit packed sum over a valid/ready handshake and accumulates a programmed number of beats into an 8-bit register, keeping carries inside each lane. Lane partitioning is 1x8, 2x4 or 4x2, selected by the same H/C/X mode flags the adder uses. It presents the final packed result with per-lane sticky overflow flags over a second valid/ready handshake.

---
 rtl/simd_lane_acc_if.sv | 40 ++++
 rtl/simd_lane_acc.sv | 188 ++++++++++++++++++
 tb/tb_simd_lane_acc.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_lane_acc_if.sv
// simd_lane_acc_if: control, beat-input and result-output bundle for the
// lane-wise SIMD accumulator. The master side is the upstream adder plus
// the downstream consumer; the slave side is the accumulator itself.
interface simd_lane_acc_if #(
    parameter int LEN_W = 4
);
    // Run control, sampled by the accumulator only while idle
    logic             start;
    logic [LEN_W-1:0] len;
    logic             h;
    logic             c;
    logic             x;

    // Beat input from the SIMD adder
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_sum;
    logic             in_cout;

    // Accumulated result towards the consumer
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_acc;
    logic [3:0]       out_ovf;
    logic             busy;

    modport master (
        output start, len, h, c, x,
        output in_valid, in_sum, in_cout,
        output out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, busy
    );

    modport slave (
        input  start, len, h, c, x,
        input  in_valid, in_sum, in_cout,
        input  out_ready,
        output in_ready, out_valid, out_acc, out_ovf, busy
    );
endinterface

// File: rtl/simd_lane_acc.sv
// simd_lane_acc: accumulates a programmed number of packed 8-bit sums from
// the SIMD adder, lane by lane (1x8, 2x4 or 4x2), with per-lane sticky
// overflow flags. Carries never cross a lane boundary.
// Optional build macro SIMD_LANE_ACC_SAT_EN: when defined, a lane that
// carries saturates to all-ones instead of wrapping.
module simd_lane_acc #(
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    simd_lane_acc_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        M_1X8 = 2'd0,
        M_2X4 = 2'd1,
        M_4X2 = 2'd2
    } mode_e;

    state_e           state_q;
    mode_e            mode_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic [7:0]       acc_q;
    logic [7:0]       acc_d;
    logic [3:0]       ovf_q;
    logic [3:0]       ovf_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             beat_fire;

    // X wins over everything; no flags at all also means one wide lane.
    function automatic mode_e mode_decode(input logic hh, input logic cc, input logic xx);
        mode_e m;
        if (xx || (!hh && !cc)) begin
            m = M_1X8;
        end else if (hh) begin
            m = M_2X4;
        end else begin
            m = M_4X2;
        end
        return m;
    endfunction

    // Lane-partitioned add. Returns {lane carries, packed lane sums}.
    // In 1x8 mode the adder's own carry-out also marks lane 0 as overflowed,
    // but only a carry out of the accumulator lane triggers saturation.
    function automatic logic [11:0] lane_add(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input mode_e      m,
                                             input logic       cout);
        logic [7:0] sum;
        logic [3:0] ovf;
        logic [8:0] s8;
        logic [4:0] s4;
        logic [2:0] s2;
        sum = '0;
        ovf = '0;
        s8  = '0;
        s4  = '0;
        s2  = '0;
        case (m)
            M_2X4: begin
                for (int i = 0; i < 2; i++) begin
                    s4 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
                    sum[4*i +: 4] = s4[3:0];
                    ovf[i] = s4[4];
`ifdef SIMD_LANE_ACC_SAT_EN
                    if (s4[4]) begin
                        sum[4*i +: 4] = 4'hF;
                    end
`endif
                end
            end
            M_4X2: begin
                for (int i = 0; i < 4; i++) begin
                    s2 = {1'b0, a[2*i +: 2]} + {1'b0, b[2*i +: 2]};
                    sum[2*i +: 2] = s2[1:0];
                    ovf[i] = s2[2];
`ifdef SIMD_LANE_ACC_SAT_EN
                    if (s2[2]) begin
                        sum[2*i +: 2] = 2'h3;
                    end
`endif
                end
            end
            default: begin
                s8 = {1'b0, a} + {1'b0, b};
                sum = s8[7:0];
                ovf[0] = s8[8] | cout;
`ifdef SIMD_LANE_ACC_SAT_EN
                if (s8[8]) begin
                    sum = 8'hFF;
                end
`endif
            end
        endcase
        return {ovf, sum};
    endfunction

    // A beat is taken whenever the block is accumulating and upstream offers one;
    // in_ready is exactly "state is ACC", so no combinational path from in_valid.
    assign beat_fire = (state_q == S_ACC) && bus.in_valid;
    assign cnt_d     = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

    // Next accumulator value and sticky overflow for the beat on the bus
    always_comb begin
        logic [11:0] res;
        res   = lane_add(acc_q, bus.in_sum, mode_q, bus.in_cout);
        acc_d = res[7:0];
        ovf_d = ovf_q | res[11:8];
    end

    // Control FSM with registered handshake outputs and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= M_1X8;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        acc_q  <= '0;
                        ovf_q  <= '0;
                        cnt_q  <= '0;
                        len_q  <= bus.len;
                        mode_q <= mode_decode(bus.h, bus.c, bus.x);
                        busy_q <= 1'b1;
                        if (bus.len == '0) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= S_ACC;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                S_ACC: begin
                    if (beat_fire) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q     <= S_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_simd_lane_acc.sv
// tb_simd_lane_acc: randomized and directed runs of the lane accumulator.
// Expected results come from an integer per-lane reference model and are
// queued at start; a monitor pops them on each output handshake.
module tb_simd_lane_acc;

    typedef struct packed {
        logic [7:0] acc;
        logic [3:0] ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    res_t expq[$];
    logic [7:0] beat_sum[16];
    logic       beat_cout[16];

    always #5 clk = ~clk;

    simd_lane_acc_if #(.LEN_W(4)) bus ();

    simd_lane_acc #(.LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane_width(input logic hh, input logic cc, input logic xx);
        if (xx || (!hh && !cc)) return 8;
        if (hh) return 4;
        return 2;
    endfunction

    // Reference: each lane is an independent integer counter of width w
    function automatic res_t model(input int n, input int w);
        int   lanes[4];
        int   mask;
        int   nl;
        int   v;
        res_t r;
        mask = (1 << w) - 1;
        nl   = 8 / w;
        r    = '0;
        for (int l = 0; l < 4; l++) lanes[l] = 0;
        for (int b = 0; b < n; b++) begin
            for (int l = 0; l < nl; l++) begin
                v = lanes[l] + ((int'(beat_sum[b]) >> (l * w)) & mask);
                if (v > mask) begin
                    r.ovf[l] = 1'b1;
`ifdef SIMD_LANE_ACC_SAT_EN
                    v = mask;
`else
                    v = v - (mask + 1);
`endif
                end
                lanes[l] = v;
            end
            if (w == 8 && beat_cout[b]) r.ovf[0] = 1'b1;
        end
        for (int l = 0; l < nl; l++) r.acc = r.acc | 8'((lanes[l] & mask) << (l * w));
        return r;
    endfunction

    // Scoreboard monitor: compare on every output handshake
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("out_acc", bus.out_acc, e.acc);
                    check("out_ovf", bus.out_ovf, e.ovf);
                end
            end
        end
    end

    // One full run: start, feed n beats (optionally with gaps), hold in DONE, drain
    task automatic run_case(input int n, input logic hh, input logic cc, input logic xx,
                            input bit gaps, input int hold);
        res_t e;
        int   i;
        int   cyc;
        e = model(n, lane_width(hh, cc, xx));
        bus.start = 1'b1;
        bus.len   = 4'(n);
        bus.h     = hh;
        bus.c     = cc;
        bus.x     = xx;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len   = 4'($urandom);
        bus.h     = 1'($urandom);
        bus.c     = 1'($urandom);
        bus.x     = 1'($urandom);
        expq.push_back(e);
        if (n == 0) begin
            check("len0_out_valid", bus.out_valid, 1);
            check("len0_acc", bus.out_acc, 0);
            check("len0_in_ready", bus.in_ready, 0);
        end else begin
            check("acc_in_ready", bus.in_ready, 1);
            check("acc_busy", bus.busy, 1);
            i = 0;
            cyc = 0;
            while (i < n && cyc < 200) begin
                bus.in_valid = gaps ? 1'($urandom % 2) : 1'b1;
                if (bus.in_valid) begin
                    bus.in_sum  = beat_sum[i];
                    bus.in_cout = beat_cout[i];
                end else begin
                    bus.in_sum  = 8'($urandom);
                    bus.in_cout = 1'($urandom);
                end
                @(posedge clk); #1;
                if (bus.in_valid) i++;
                cyc++;
                if (i < n) check("mid_out_valid", bus.out_valid, 0);
            end
            bus.in_valid = 1'b0;
            if (i < n) check("beat_timeout", i, n);
            check("latency_out_valid", bus.out_valid, 1);
            check("done_in_ready", bus.in_ready, 0);
        end
        for (int k = 0; k < hold; k++) begin
            bus.start    = 1'($urandom);
            bus.len      = 4'($urandom);
            bus.in_valid = 1'($urandom);
            bus.in_sum   = 8'($urandom);
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_acc", bus.out_acc, e.acc);
            check("hold_ovf", bus.out_ovf, e.ovf);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_busy", bus.busy, 1);
        end
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_busy", bus.busy, 0);
        check("persist_acc", bus.out_acc, e.acc);
        check("persist_ovf", bus.out_ovf, e.ovf);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_acc"}, bus.out_acc, 0);
        check({tag, "_out_ovf"}, bus.out_ovf, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.h         = 1'b0;
        bus.c         = 1'b0;
        bus.x         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_cout   = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            beat_sum[k]  = '0;
            beat_cout[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1x8, three back-to-back beats
        beat_sum[0] = 8'h10; beat_sum[1] = 8'h20; beat_sum[2] = 8'h30;
        run_case(3, 1'b0, 1'b0, 1'b1, 1'b0, 0);

        // 1x8, adder carry-out flags lane 0
        beat_sum[0] = 8'h05; beat_cout[0] = 1'b1;
        run_case(1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        beat_cout[0] = 1'b0;

        // 4x2, every lane carries
        beat_sum[0] = 8'hFF; beat_sum[1] = 8'hFF;
        run_case(2, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // 2x4, both lanes carry, held in DONE for 5 cycles
        beat_sum[0] = 8'h9F; beat_sum[1] = 8'h91;
        run_case(2, 1'b1, 1'b0, 1'b0, 1'b0, 5);

        // 2x4 with in_valid toggling
        for (int k = 0; k < 5; k++) beat_sum[k] = 8'($urandom);
        run_case(5, 1'b1, 1'b0, 1'b0, 1'b1, 1);

        // zero-length run
        run_case(0, 1'b0, 1'b1, 1'b0, 1'b0, 2);

        // reset after one of three beats
        bus.start = 1'b1; bus.len = 4'd3; bus.x = 1'b1; bus.h = 1'b0; bus.c = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_sum = 8'h11;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midrst");
        rst = 1'b0;
        beat_sum[0] = 8'h01; beat_sum[1] = 8'h02; beat_sum[2] = 8'h03;
        run_case(3, 1'b0, 1'b0, 1'b1, 1'b0, 0);

        // randomized runs
        for (int r = 0; r < 30; r++) begin
            int n;
            n = int'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) begin
                beat_sum[k]  = 8'($urandom);
                beat_cout[k] = 1'($urandom);
            end
            run_case(n, 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
